// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   An accepted start runs WIDTH one-bit-per-cycle iterations (RUN), then one
//   sign-fixup cycle (FIXUP) that commits HI/LO and pulses done.
//   mthi/mtlo arrive on the hlwrite port and are honoured only while idle.
//
// Ports
//   clk_i       rising-edge clock
//   reset_ni    synchronous active-low reset
//   start_i     launch op_i on srca_i/srcb_i (ignored while busy)
//   op_i        00 multu, 01 mult, 10 divu, 11 div
//   srca_i      multiplicand / dividend
//   srcb_i      multiplier / divisor
//   flush_i     abort the operation in flight, HI/LO untouched
//   hlwrite_i   direct HI/LO write (idle only)
//   hlsel_i     1 = HI, 0 = LO for hlwrite_i
//   hlwdata_i   data for hlwrite_i
//   busy_o      registered, high in RUN and FIXUP
//   done_o      registered one-cycle pulse when HI/LO are updated
//   divzero_o   sticky divide-by-zero flag, cleared by the next accepted start
//   hi_o, lo_o  architectural HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  input  logic             hlwrite_i,
  input  logic             hlsel_i,
  input  logic [WIDTH-1:0] hlwdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_e;

  state_e             state_q, state_d;
  logic               div_q, div_d;       // operation is a divide
  logic               negq_q, negq_d;     // negate quotient / product
  logic               negr_q, negr_d;     // negate remainder
  logic               dz_q, dz_d;         // divisor was zero
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes; unsigned ops pass operands through untouched.
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sa    = op_i[0] & srca_i[WIDTH-1];
  assign sb    = op_i[0] & srcb_i[WIDTH-1];
  assign abs_a = sa ? -srca_i : srca_i;
  assign abs_b = sb ? -srcb_i : srcb_i;

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right, keeping the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract when it fits. A zero divisor always "fits", so the quotient becomes
  // all ones and the remainder ends up holding the dividend magnitude.
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opb_q};
  assign div_diff  = div_trial - {1'b0, opb_q};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // Sign fixups applied in FIXUP.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // A start always claims the cycle, so a coincident hlwrite is lost
          // even when flush drops the start itself.
          if (!flush_i) begin
            state_d   = S_RUN;
            div_d     = op_i[1];
            negq_d    = sa ^ sb;
            negr_d    = sa;
            dz_d      = op_i[1] & (srcb_i == '0);
            count_d   = '0;
            divzero_d = 1'b0;
            acc_d     = op_i[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            opb_d     = op_i[1] ? abs_b : abs_a;
          end
        end else if (hlwrite_i) begin
          if (hlsel_i) hi_d = hlwdata_i;
          else         lo_d = hlwdata_i;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = div_q ? div_step : mul_step;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          if (div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      div_q     <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dz_q      <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dz_q      <= dz_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign divzero_o = divzero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule
